// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory side: cache FSM states, default
// geometry and the reset vector used by the fetch stage.
package imem_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    localparam int LINES_DEF      = 64;
    localparam int LINE_WORDS_DEF = 4;
    localparam int OB             = 2 + $clog2(LINE_WORDS_DEF);
    localparam int IB             = $clog2(LINES_DEF);
    localparam int TB             = 32 - OB - IB;

    localparam logic [31:0] MIPS_START_ADDR = 32'hBFC0_0000;

endpackage

// File: rtl/imem_icache_array.sv
// Tag/valid/data storage for the direct-mapped instruction cache.
// Asynchronous lookup, synchronous fill, single-cycle clear of every valid bit.
module imem_icache_array
    import imem_pkg::*;
#(
    parameter int LINES      = LINES_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int IDX_W      = $clog2(LINES),
    parameter int WRD_W      = $clog2(LINE_WORDS),
    parameter int TAG_W      = 32 - 2 - WRD_W - IDX_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] rd_idx,
    input  logic [WRD_W-1:0] rd_word,
    output logic             rd_valid,
    output logic [TAG_W-1:0] rd_tag,
    output logic [31:0]      rd_data,
    input  logic             wr_en,
    input  logic [IDX_W-1:0] wr_idx,
    input  logic [WRD_W-1:0] wr_word,
    input  logic [31:0]      wr_data,
    input  logic             tag_we,
    input  logic [TAG_W-1:0] tag_wdata,
    input  logic             valid_set,
    input  logic             valid_clr
);

    logic [LINES-1:0] valid_q;
    logic [LINES-1:0] valid_d;
    logic [TAG_W-1:0] tag_q  [LINES];
    logic [31:0]      data_q [LINES*LINE_WORDS];

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[{rd_idx, rd_word}];

    // Next valid vector: a bulk clear beats a simultaneous line fill.
    always_comb begin
        valid_d = valid_q;
        if (valid_clr) begin
            valid_d = '0;
        end else if (valid_set) begin
            valid_d[wr_idx] = 1'b1;
        end else begin
            valid_d = valid_q;
        end
    end

    // Valid bits register, cleared asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else begin
            valid_q <= valid_d;
        end
    end

    // Tag and data RAM writes.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[{wr_idx, wr_word}] <= wr_data;
        end
        if (tag_we) begin
            tag_q[wr_idx] <= tag_wdata;
        end
    end

endmodule

// File: rtl/imem_icache.sv
// Direct-mapped read-only instruction cache: zero-latency hit path, whole-line
// refill one word per memory handshake, hit/miss counters.
module imem_icache
    import imem_pkg::*;
#(
    parameter int LINES      = LINES_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] i_addr,
    output logic [31:0] o_data,
    output logic        o_hit,
    output logic        o_stall,
    input  logic        i_invalidate,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_ack,
    input  logic [31:0] i_mem_rdata,
    output logic [31:0] o_hit_cnt,
    output logic [31:0] o_miss_cnt
);

    localparam int WRD_W = $clog2(LINE_WORDS);
    localparam int OFF_W = 2 + WRD_W;
    localparam int IDX_W = $clog2(LINES);
    localparam int TAG_W = 32 - OFF_W - IDX_W;
    localparam logic [WRD_W-1:0] CNT_ONE   = {{(WRD_W-1){1'b0}}, 1'b1};
    localparam logic [WRD_W-1:0] LAST_WORD = {WRD_W{1'b1}};

    state_e              state_q, state_d;
    logic [31-OFF_W:0]   base_q, base_d;
    logic [WRD_W-1:0]    cnt_q, cnt_d;
    logic                abort_q, abort_d;
    logic [31:0]         hit_cnt_q, hit_cnt_d;
    logic [31:0]         miss_cnt_q, miss_cnt_d;

    logic                rd_valid_s;
    logic [TAG_W-1:0]    rd_tag_s;
    logic [31:0]         rd_data_s;
    logic                lookup_hit_s;
    logic                fill_we_s;
    logic                fill_last_s;
    logic                unused_addr_bits;

    assign unused_addr_bits = ^i_addr[1:0];

    imem_icache_array #(
        .LINES      (LINES),
        .LINE_WORDS (LINE_WORDS),
        .IDX_W      (IDX_W),
        .WRD_W      (WRD_W),
        .TAG_W      (TAG_W)
    ) u_array (
        .clk       (clk),
        .rst       (rst),
        .rd_idx    (i_addr[OFF_W +: IDX_W]),
        .rd_word   (i_addr[2 +: WRD_W]),
        .rd_valid  (rd_valid_s),
        .rd_tag    (rd_tag_s),
        .rd_data   (rd_data_s),
        .wr_en     (fill_we_s),
        .wr_idx    (base_q[IDX_W-1:0]),
        .wr_word   (cnt_q),
        .wr_data   (i_mem_rdata),
        .tag_we    (fill_last_s),
        .tag_wdata (base_q[31-OFF_W -: TAG_W]),
        .valid_set (fill_last_s & ~abort_q & ~i_invalidate),
        .valid_clr (i_invalidate)
    );

    assign lookup_hit_s = (state_q == IDLE) && rd_valid_s && (rd_tag_s == i_addr[31 -: TAG_W]);
    assign o_hit        = lookup_hit_s;
    assign o_data       = rd_data_s;
    assign o_stall      = rst | ~lookup_hit_s;
    assign o_mem_req    = (state_q == REFILL);
    assign o_mem_addr   = {base_q, cnt_q, 2'b00};
    assign o_hit_cnt    = hit_cnt_q;
    assign o_miss_cnt   = miss_cnt_q;

    // Refill FSM, word counter, abort flag and statistics.
    always_comb begin
        state_d     = state_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        abort_d     = abort_q;
        hit_cnt_d   = hit_cnt_q;
        miss_cnt_d  = miss_cnt_q;
        fill_we_s   = 1'b0;
        fill_last_s = 1'b0;
        case (state_q)
            IDLE: begin
                if (i_invalidate) begin
                    state_d = IDLE;
                end else if (lookup_hit_s) begin
                    hit_cnt_d = hit_cnt_q + 32'd1;
                end else begin
                    state_d    = REFILL;
                    base_d     = i_addr[31:OFF_W];
                    cnt_d      = '0;
                    miss_cnt_d = miss_cnt_q + 32'd1;
                end
            end
            REFILL: begin
                if (i_invalidate) begin
                    abort_d = 1'b1;
                end else begin
                    abort_d = abort_q;
                end
                if (i_mem_ack) begin
                    fill_we_s = 1'b1;
                    cnt_d     = cnt_q + CNT_ONE;
                    if (cnt_q == LAST_WORD) begin
                        fill_last_s = 1'b1;
                        abort_d     = 1'b0;
                        state_d     = IDLE;
                    end else begin
                        state_d = REFILL;
                    end
                end else begin
                    state_d = REFILL;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            base_q     <= '0;
            cnt_q      <= '0;
            abort_q    <= 1'b0;
            hit_cnt_q  <= 32'd0;
            miss_cnt_q <= 32'd0;
        end else begin
            state_q    <= state_d;
            base_q     <= base_d;
            cnt_q      <= cnt_d;
            abort_q    <= abort_d;
            hit_cnt_q  <= hit_cnt_d;
            miss_cnt_q <= miss_cnt_d;
        end
    end

endmodule

// File: tb/tb_imem_icache.sv
// Self-checking bench for imem_icache: directed scenarios plus randomized fetches
// against a behavioural cache model and a configurable-latency memory responder.
module tb_imem_icache;

    localparam int LW = 4;
    localparam int NL = 64;

    logic        clk;
    logic        rst;
    logic [31:0] i_addr;
    logic [31:0] o_data;
    logic        o_hit;
    logic        o_stall;
    logic        i_invalidate;
    logic        o_mem_req;
    logic [31:0] o_mem_addr;
    logic        i_mem_ack;
    logic [31:0] i_mem_rdata;
    logic [31:0] o_hit_cnt;
    logic [31:0] o_miss_cnt;

    int          checks = 0;
    int          errors = 0;
    int          gap    = 0;
    logic [31:0] model_hits;
    logic [31:0] model_misses;
    bit          mvalid [NL];
    logic [31:0] mtag   [NL];
    logic [31:0] acked_q [$];

    imem_icache dut (
        .clk          (clk),
        .rst          (rst),
        .i_addr       (i_addr),
        .o_data       (o_data),
        .o_hit        (o_hit),
        .o_stall      (o_stall),
        .i_invalidate (i_invalidate),
        .o_mem_req    (o_mem_req),
        .o_mem_addr   (o_mem_addr),
        .i_mem_ack    (i_mem_ack),
        .i_mem_rdata  (i_mem_rdata),
        .o_hit_cnt    (o_hit_cnt),
        .o_miss_cnt   (o_miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] memf(input logic [31:0] a);
        logic [31:0] w;
        w = {a[31:2], 2'b00};
        return (w * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory responder: acks after `gap` idle cycles of a pending request.
    initial begin : responder
        int          wcnt;
        bit          pend;
        logic [31:0] prev_addr;
        wcnt = 0;
        pend = 1'b0;
        prev_addr = 32'd0;
        i_mem_ack = 1'b0;
        i_mem_rdata = 32'd0;
        forever begin
            @(negedge clk);
            if (rst || !o_mem_req) begin
                i_mem_ack = 1'b0;
                wcnt = 0;
                pend = 1'b0;
            end else begin
                if (pend) begin
                    checks++;
                    if (o_mem_addr !== prev_addr) begin
                        errors++;
                        $display("FAIL addr_stable: got %h want %h", o_mem_addr, prev_addr);
                    end
                end
                if (wcnt >= gap) begin
                    i_mem_ack = 1'b1;
                    i_mem_rdata = memf(o_mem_addr);
                    acked_q.push_back(o_mem_addr);
                    wcnt = 0;
                    pend = 1'b0;
                end else begin
                    i_mem_ack = 1'b0;
                    wcnt++;
                    pend = 1'b1;
                    prev_addr = o_mem_addr;
                end
            end
        end
    end

    task automatic model_clear();
        for (int i = 0; i < NL; i++) mvalid[i] = 1'b0;
    endtask

    task automatic check_counters(input string nm);
        checks++;
        if (o_hit_cnt !== model_hits) begin
            errors++;
            $display("FAIL %s hit_cnt: got %h want %h", nm, o_hit_cnt, model_hits);
        end
        checks++;
        if (o_miss_cnt !== model_misses) begin
            errors++;
            $display("FAIL %s miss_cnt: got %h want %h", nm, o_miss_cnt, model_misses);
        end
    endtask

    // One fetch until hit; inv_at >= 1 pulses invalidate in that refill cycle.
    task automatic fetch(input logic [31:0] a, input int inv_at, input string nm);
        int          idx;
        logic [31:0] tg;
        bit          exp_hit;
        bit          use_inv;
        int          nrep;
        int          cyc;
        int          exp_cyc;
        logic [31:0] base;
        idx = int'((a / 32'd16) % NL);
        tg = a / 32'd1024;
        exp_hit = mvalid[idx] && (mtag[idx] == tg);
        use_inv = !exp_hit && (inv_at >= 0);
        nrep = use_inv ? 2 : 1;
        base = (a / 32'd16) * 32'd16;
        exp_cyc = exp_hit ? 0 : nrep * (LW * (gap + 1) + 1);
        acked_q.delete();
        cyc = 0;
        forever begin
            @(negedge clk);
            if (cyc == 0) i_addr = a;
            i_invalidate = (cyc == inv_at);
            #1;
            if (o_hit === 1'b1 || cyc >= 400) break;
            checks++;
            if (o_stall !== 1'b1) begin
                errors++;
                $display("FAIL %s stall_during_miss: got %b want 1 (cycle %0d)", nm, o_stall, cyc);
            end
            cyc++;
        end
        i_invalidate = 1'b0;
        checks++;
        if (cyc !== exp_cyc) begin
            errors++;
            $display("FAIL %s stall_cycles: got %0d want %0d", nm, cyc, exp_cyc);
        end
        checks++;
        if (o_data !== memf(a) || o_stall !== 1'b0) begin
            errors++;
            $display("FAIL %s hit_data: got %h stall %b want %h stall 0", nm, o_data, o_stall, memf(a));
        end
        if (!exp_hit) begin
            checks++;
            if (acked_q.size() != nrep * LW) begin
                errors++;
                $display("FAIL %s refill_words: got %0d want %0d", nm, acked_q.size(), nrep * LW);
            end
            for (int k = 0; k < acked_q.size() && k < nrep * LW; k++) begin
                checks++;
                if (acked_q[k] !== base + 32'(4 * (k % LW))) begin
                    errors++;
                    $display("FAIL %s mem_addr[%0d]: got %h want %h", nm, k, acked_q[k], base + 32'(4 * (k % LW)));
                end
            end
            if (use_inv) model_clear();
            model_misses = model_misses + 32'(nrep);
            mvalid[idx] = 1'b1;
            mtag[idx] = tg;
        end
        model_hits = model_hits + 32'd1;
        @(posedge clk);
        #1;
        check_counters(nm);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        i_addr = 32'd0;
        i_invalidate = 1'b0;
        model_hits = 32'd0;
        model_misses = 32'd0;
        model_clear();
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (o_stall !== 1'b1 || o_hit !== 1'b0 || o_mem_req !== 1'b0 || o_mem_addr !== 32'd0) begin
            errors++;
            $display("FAIL reset_outputs: got stall %b hit %b req %b addr %h want 1 0 0 0",
                     o_stall, o_hit, o_mem_req, o_mem_addr);
        end
        check_counters("reset");
        rst = 1'b0;
    endtask

    task automatic test_cold_miss();
        gap = 0;
        fetch(32'h0, -1, "cold_miss");
        fetch(32'h4, -1, "cold_hit4");
        fetch(32'h8, -1, "cold_hit8");
        fetch(32'hC, -1, "cold_hitC");
        checks++;
        if (o_miss_cnt !== 32'd1 || o_hit_cnt !== 32'd4) begin
            errors++;
            $display("FAIL cold_totals: got miss %0d hit %0d want 1 4", o_miss_cnt, o_hit_cnt);
        end
    endtask

    task automatic test_conflict();
        gap = 0;
        fetch(32'h400, -1, "conflict_400");
        fetch(32'h0, -1, "conflict_refetch0");
    endtask

    task automatic test_slow_mem();
        gap = 2;
        fetch(32'h104, -1, "slow_miss");
        fetch(32'h10C, -1, "slow_hit");
        gap = 0;
    endtask

    task automatic test_invalidate();
        logic [31:0] m0;
        gap = 0;
        m0 = o_miss_cnt;
        fetch(32'h20, 2, "inv_refill");
        checks++;
        if (o_miss_cnt !== m0 + 32'd2) begin
            errors++;
            $display("FAIL inv_miss_twice: got %0d want %0d", o_miss_cnt, m0 + 32'd2);
        end
        // Invalidate while idle on a hitting address: no count, line dropped.
        @(negedge clk);
        i_addr = 32'h20;
        i_invalidate = 1'b1;
        @(posedge clk);
        #1;
        i_invalidate = 1'b0;
        checks++;
        if (o_hit !== 1'b0) begin
            errors++;
            $display("FAIL idle_inv_drops: got hit %b want 0", o_hit);
        end
        check_counters("idle_inv");
        model_clear();
        fetch(32'h20, -1, "idle_inv_remiss");
    endtask

    task automatic test_reset_mid();
        gap = 1;
        @(negedge clk);
        i_addr = 32'h44;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (o_mem_req !== 1'b0 || o_stall !== 1'b1) begin
            errors++;
            $display("FAIL reset_mid: got req %b stall %b want 0 1", o_mem_req, o_stall);
        end
        model_clear();
        model_hits = 32'd0;
        model_misses = 32'd0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check_counters("reset_mid");
        gap = 0;
        fetch(32'h0, -1, "after_reset_miss");
    endtask

    task automatic test_wrap();
        gap = 0;
        fetch(32'h0, -1, "wrap_prep");
        force dut.hit_cnt_q = 32'hFFFF_FFFF;
        @(negedge clk);
        release dut.hit_cnt_q;
        #1;
        checks++;
        if (o_hit_cnt !== 32'hFFFF_FFFF) begin
            errors++;
            $display("FAIL wrap_preload: got %h want ffffffff", o_hit_cnt);
        end
        model_hits = 32'hFFFF_FFFF + 32'd1;
        @(posedge clk);
        #1;
        check_counters("wrap");
    endtask

    task automatic test_random();
        logic [31:0] a;
        int          inv;
        for (int n = 0; n < 40; n++) begin
            gap = int'($urandom_range(0, 2));
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 7) << 4) | ($urandom_range(0, 15));
            inv = ($urandom_range(0, 5) == 0) ? int'($urandom_range(1, LW * (gap + 1))) : -1;
            fetch(a, inv, "random");
        end
        gap = 0;
    endtask

    initial begin : main
        test_reset();
        test_cold_miss();
        test_conflict();
        test_slow_mem();
        test_invalidate();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
